// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - default address/data widths of the 32 x 32-bit data RAM
//   - port identifiers used to tag read returns
//   - return-tag type carried down the read-latency pipeline
package dmem_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // One slot of the read-return pipeline: is there a read in flight,
    // and which requester gets the data when it leaves the RAM.
    typedef struct packed {
        logic valid;
        logic port;
    } rtag_t;

    localparam rtag_t RTAG_IDLE = '{valid: 1'b0, port: PORT_A};

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_a_i, req_b_i   requests from port A / port B
//   gnt_a_o, gnt_b_o   one-hot (or zero) grant, combinational from the
//                      requests and the registered priority pointer
// The pointer names the side that wins a tie; it flips to the other side
// after every grant and holds when nothing is granted, so two permanent
// requesters alternate strictly.
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection and next priority pointer.
    always_comb begin
        gnt_a_o = 1'b0;
        gnt_b_o = 1'b0;
        ptr_d   = ptr_q;
        if (req_a_i && (!req_b_i || (ptr_q == PORT_A))) begin
            gnt_a_o = 1'b1;
            ptr_d   = PORT_B;
        end else if (req_b_i) begin
            gnt_b_o = 1'b1;
            ptr_d   = PORT_A;
        end else begin
            ptr_d   = ptr_q;
        end
    end

    // Priority pointer register; A wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PORT_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the processor load/store stage
// (port A) and the debug/loader port (port B).
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata        port A request (held until a_gnt)
//   a_gnt                            port A request accepted this cycle
//   a_rvalid/a_rdata                 port A read return (rdata holds otherwise)
//   b_*                              same for port B
//   mem_en/mem_we/mem_addr/mem_wdata RAM command, combinational copy of the
//                                    granted request
//   mem_rdata                        RAM read data, RD_LAT cycles after issue
// RD_LAT (legal 1..2) sizes the return-tag pipeline so that the tag leaves
// in the same cycle the RAM presents the data; the data is then registered,
// giving grant-to-rvalid of RD_LAT+1 cycles.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Requests are masked while reset is held so that no grant, and hence
    // no RAM command, can leak out during reset.
    logic a_req_s;
    logic b_req_s;

    rtag_t pipe_q [RD_LAT];
    rtag_t pipe_d [RD_LAT];
    rtag_t push_s;
    rtag_t exit_s;

    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q,  a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q,  b_rdata_d;

    assign a_req_s = a_req & ~rst;
    assign b_req_s = b_req & ~rst;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req_a_i (a_req_s),
        .req_b_i (b_req_s),
        .gnt_a_o (a_gnt),
        .gnt_b_o (b_gnt)
    );

    // RAM command mux: follow the granted requester, idle otherwise.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (a_gnt) begin
            mem_en    = 1'b1;
            mem_we    = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_en    = 1'b1;
            mem_we    = b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end else begin
            mem_en    = 1'b0;
        end
    end

    // Return-tag pipeline next state: writes and idle cycles push an empty slot.
    always_comb begin
        push_s.valid = mem_en & ~mem_we;
        push_s.port  = b_gnt ? PORT_B : PORT_A;
        pipe_d[0]    = push_s;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        exit_s = pipe_q[RD_LAT-1];
    end

    // Return-tag pipeline register; reset drops every read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= RTAG_IDLE;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // Steer the exiting RAM data to the tagged port; rdata holds otherwise.
    always_comb begin
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        if (exit_s.valid) begin
            if (exit_s.port == PORT_A) begin
                a_rvalid_d = 1'b1;
                a_rdata_d  = mem_rdata;
            end else begin
                b_rvalid_d = 1'b1;
                b_rdata_d  = mem_rdata;
            end
        end else begin
            a_rvalid_d = 1'b0;
        end
    end

    // Registered read-return outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= {DATA_W{1'b0}};
            b_rdata_q  <= {DATA_W{1'b0}};
        end else begin
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. Two instances share the same request stimulus:
// dut1 with RD_LAT=1 and dut2 with RD_LAT=2, each with its own RAM model.
// A reference pointer and reference memory predict grants and read data;
// expected returns are queued at grant time and popped by per-instance
// monitors whenever rvalid is seen.
module tb_dmem_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = 5'd0, b_addr = 5'd0;
    logic [DW-1:0] a_wdata = 32'd0, b_wdata = 32'd0;

    logic          a_gnt1, b_gnt1, a_rvalid1, b_rvalid1, mem_en1, mem_we1;
    logic [DW-1:0] a_rdata1, b_rdata1, mem_wdata1, mem_rdata1;
    logic [AW-1:0] mem_addr1;
    logic          a_gnt2, b_gnt2, a_rvalid2, b_rvalid2, mem_en2, mem_we2;
    logic [DW-1:0] a_rdata2, b_rdata2, mem_wdata2, mem_rdata2;
    logic [AW-1:0] mem_addr2;

    logic [DW-1:0] ram1 [32];
    logic [DW-1:0] ram2 [32];
    logic [DW-1:0] ram2_s1;

    logic [DW-1:0] ref_mem [32];
    logic          ptr_m = 1'b0;
    exp_t          qa1[$], qb1[$], qa2[$], qb2[$];
    logic [DW-1:0] last_a1, last_b1, last_a2, last_b2;
    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt2), .a_rvalid(a_rvalid2), .a_rdata(a_rdata2),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt2), .b_rvalid(b_rvalid2), .b_rdata(b_rdata2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
    );

    // Cycle counter: holds N throughout the cycle that starts at edge N.
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_en1) begin
            if (mem_we1) ram1[mem_addr1] <= mem_wdata1;
            else         mem_rdata1     <= ram1[mem_addr1];
        end
    end

    // RAM model with two-cycle read (extra output register).
    always @(posedge clk) begin
        if (mem_en2) begin
            if (mem_we2) ram2[mem_addr2] <= mem_wdata2;
            else         ram2_s1        <= ram2[mem_addr2];
        end
        mem_rdata2 <= ram2_s1;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Monitor for dut1: order, latency, data, hold, exclusivity.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst) begin
            last_a1 = 32'd0;
            last_b1 = 32'd0;
        end else begin
            chk1("rv_excl1", a_rvalid1 & b_rvalid1, 1'b0);
            if (a_rvalid1) begin
                if (qa1.size() == 0) chk1("a_stray1", a_rvalid1, 1'b0);
                else begin
                    e = qa1.pop_front();
                    chk("a_lat1", cyc, e.due);
                    chk("a_data1", a_rdata1, e.data);
                end
                last_a1 = a_rdata1;
            end else begin
                chk("a_hold1", a_rdata1, last_a1);
                if (qa1.size() != 0 && qa1[0].due <= cyc) begin
                    e = qa1.pop_front();
                    chk1("a_miss1", a_rvalid1, 1'b1);
                end
            end
            if (b_rvalid1) begin
                if (qb1.size() == 0) chk1("b_stray1", b_rvalid1, 1'b0);
                else begin
                    e = qb1.pop_front();
                    chk("b_lat1", cyc, e.due);
                    chk("b_data1", b_rdata1, e.data);
                end
                last_b1 = b_rdata1;
            end else begin
                chk("b_hold1", b_rdata1, last_b1);
                if (qb1.size() != 0 && qb1[0].due <= cyc) begin
                    e = qb1.pop_front();
                    chk1("b_miss1", b_rvalid1, 1'b1);
                end
            end
        end
    end

    // Monitor for dut2 (RD_LAT=2).
    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst) begin
            last_a2 = 32'd0;
            last_b2 = 32'd0;
        end else begin
            chk1("rv_excl2", a_rvalid2 & b_rvalid2, 1'b0);
            if (a_rvalid2) begin
                if (qa2.size() == 0) chk1("a_stray2", a_rvalid2, 1'b0);
                else begin
                    e = qa2.pop_front();
                    chk("a_lat2", cyc, e.due);
                    chk("a_data2", a_rdata2, e.data);
                end
                last_a2 = a_rdata2;
            end else begin
                chk("a_hold2", a_rdata2, last_a2);
                if (qa2.size() != 0 && qa2[0].due <= cyc) begin
                    e = qa2.pop_front();
                    chk1("a_miss2", a_rvalid2, 1'b1);
                end
            end
            if (b_rvalid2) begin
                if (qb2.size() == 0) chk1("b_stray2", b_rvalid2, 1'b0);
                else begin
                    e = qb2.pop_front();
                    chk("b_lat2", cyc, e.due);
                    chk("b_data2", b_rdata2, e.data);
                end
                last_b2 = b_rdata2;
            end else begin
                chk("b_hold2", b_rdata2, last_b2);
                if (qb2.size() != 0 && qb2[0].due <= cyc) begin
                    e = qb2.pop_front();
                    chk1("b_miss2", b_rvalid2, 1'b1);
                end
            end
        end
    end

    // Drive one cycle of requests, check grants/RAM command, queue expectations.
    task automatic step(input logic ar, input logic aw, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                        input logic br, input logic bw, input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
        logic ga, gb;
        @(posedge clk); #1;
        a_req = ar; a_we = aw; a_addr = aad; a_wdata = awd;
        b_req = br; b_we = bw; b_addr = bad; b_wdata = bwd;
        #3;
        ga = ar && !rst && (!br || (ptr_m == 1'b0));
        gb = br && !rst && !ga;
        chk1("a_gnt1", a_gnt1, ga);
        chk1("b_gnt1", b_gnt1, gb);
        chk1("a_gnt2", a_gnt2, ga);
        chk1("b_gnt2", b_gnt2, gb);
        chk1("mem_en1", mem_en1, ga | gb);
        chk1("mem_we1", mem_we1, (ga & aw) | (gb & bw));
        if (ga) begin
            chk("mem_addr1", {27'd0, mem_addr1}, {27'd0, aad});
            if (aw) begin
                chk("mem_wdata1", mem_wdata1, awd);
                ref_mem[aad] = awd;
            end else begin
                qa1.push_back('{data: ref_mem[aad], due: cyc + 2});
                qa2.push_back('{data: ref_mem[aad], due: cyc + 3});
            end
            ptr_m = 1'b1;
        end else if (gb) begin
            chk("mem_addr1", {27'd0, mem_addr1}, {27'd0, bad});
            if (bw) begin
                chk("mem_wdata1", mem_wdata1, bwd);
                ref_mem[bad] = bwd;
            end else begin
                qb1.push_back('{data: ref_mem[bad], due: cyc + 2});
                qb2.push_back('{data: ref_mem[bad], due: cyc + 3});
            end
            ptr_m = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, "_a_gnt"},    a_gnt1 | a_gnt2, 1'b0);
        chk1({tag, "_b_gnt"},    b_gnt1 | b_gnt2, 1'b0);
        chk1({tag, "_a_rvalid"}, a_rvalid1 | a_rvalid2, 1'b0);
        chk1({tag, "_b_rvalid"}, b_rvalid1 | b_rvalid2, 1'b0);
        chk({tag, "_a_rdata"},   a_rdata1 | a_rdata2, 32'd0);
        chk({tag, "_b_rdata"},   b_rdata1 | b_rdata2, 32'd0);
        chk1({tag, "_mem_en"},   mem_en1 | mem_en2, 1'b0);
        chk1({tag, "_mem_we"},   mem_we1 | mem_we2, 1'b0);
        chk({tag, "_mem_addr"},  {27'd0, mem_addr1 | mem_addr2}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata1 | mem_wdata2, 32'd0);
    endtask

    initial begin
        // Power-on reset, with a request pending to prove it is masked.
        a_req = 1'b1; a_addr = 5'd4;
        #2;
        chk_zero("por");
        a_req = 1'b0; a_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single port: write then read back on A, B idle.
        step(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b0, 5'd3, 32'd0,        1'b0, 1'b0, 5'd0, 32'd0);
        idle(3);

        // Preload through port A.
        step(1'b1, 1'b1, 5'd1,  32'h0000_0011, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b1, 5'd2,  32'h0000_0022, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b1, 5'd31, 32'h3131_3131, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b1, 5'd0,  32'h0000_F00D, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b1, 5'd9,  32'h0000_0099, 1'b0, 1'b0, 5'd0, 32'd0);

        // Contention: B alone first so the pointer sits on A, then both read.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd2, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b0, 5'd2, 32'd0);

        // Write/read race on @7: B writes while A waits, A reads next cycle.
        step(1'b1, 1'b0, 5'd1, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b0, 5'd7, 32'd0, 1'b1, 1'b1, 5'd7, 32'h0000_0055);
        step(1'b1, 1'b0, 5'd7, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Withdraw: B denied against A, drops its write; @9 must be untouched.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd2, 32'd0);
        step(1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b1, 5'd9, 32'h0000_0BAD);
        idle(1);
        step(1'b1, 1'b0, 5'd9, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b0, 5'd2, 32'd0);

        // Address wrap, back-to-back reads @31 then @0 from both ports.
        step(1'b1, 1'b0, 5'd31, 32'd0, 1'b0, 1'b0, 5'd0,  32'd0);
        step(1'b1, 1'b0, 5'd0,  32'd0, 1'b0, 1'b0, 5'd0,  32'd0);
        step(1'b0, 1'b0, 5'd0,  32'd0, 1'b1, 1'b0, 5'd31, 32'd0);
        step(1'b0, 1'b0, 5'd0,  32'd0, 1'b1, 1'b0, 5'd0,  32'd0);
        idle(4);

        // Reset with reads in flight.
        step(1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b0, 5'd2, 32'd0);
        step(1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b0, 5'd2, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        qa1.delete(); qb1.delete(); qa2.delete(); qb2.delete();
        ptr_m = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(4);
        step(1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b0, 5'd2, 32'd0);
        step(1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b0, 5'd2, 32'd0);

        // Bounded drain, then every queued return must have been seen.
        idle(6);
        chk("drain", qa1.size() + qb1.size() + qa2.size() + qb2.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory (32-word x 32-bit synchronous block RAM, registered read) between two requesters: port A = processor load/store stage, port B = debug/loader port.
- One access issued per cycle, round-robin grant, valid/ready request handshake, tagged read-return pipeline matched to the RAM read latency.
- Sits between the processor memory stage / debug unit and the data memory wrapper; drives the RAM enable, write-enable, address and write data, and receives its read data.

Parameters:
- ADDR_W, 5, word address width (32 words)
- DATA_W, 32, data width
- RD_LAT, 1, RAM read latency in cycles (legal 1..2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  port A request valid
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  ADDR_W  port A word address
- a_wdata  in  DATA_W  port A write data
- a_gnt  out  1  port A request accepted this cycle
- a_rvalid  out  1  port A read data valid
- a_rdata  out  DATA_W  port A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after a read issue

Behaviour:
- Clock clk; reset rst is asynchronous and active-high. During/after reset: a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0, priority pointer = A, return pipeline cleared.
- Grant is combinational from the current req inputs and the registered priority pointer: only A requesting -> A; only B requesting -> B; both -> pointer side. At most one gnt high per cycle; gnt never asserts without the matching req.
- Handshake: the transfer occurs in the cycle req&&gnt is high. A requester holds req/we/addr/wdata stable until granted; withdrawing req before grant is legal and leaves no side effects.
- Pointer update: after a grant to A the pointer moves to B, and vice versa; pointer is unchanged in cycles with no grant. Under two continuous requesters, grants alternate strictly A,B,A,B.
- Memory drive: mem_en/mem_we/mem_addr/mem_wdata are combinational copies of the granted request (mem_en=1 on any grant, mem_we=granted we). With no grant, mem_en=0 and mem_we=0.
- Read return: each granted read pushes {valid, port id} into an RD_LAT-deep shift register. When the entry exits, the rvalid of the tagged port pulses high for 1 cycle and its rdata is registered from mem_rdata. Writes push valid=0. Read latency is exactly RD_LAT+1 cycles from the grant edge to the rvalid edge as seen at requester outputs (RD_LAT=1: gnt in cycle N -> rvalid in cycle N+2).
- rdata holds its last value when rvalid=0.
- Back-to-back reads are fully pipelined, one per cycle, with returns in issue order. Returns to A and B never coincide.
- Read-after-write to the same address in consecutive cycles returns the new data. This relies on RAM write-then-read ordering and needs no forwarding.
- Reset mid-operation: in-flight reads are discarded and no rvalid fires after reset deassertion for pre-reset issues.
- Address wraps naturally at 2^ADDR_W; no range check.

Decomposition:
- Shared package dmem_pkg: ADDR_W/DATA_W defaults, port-id constants PORT_A=0/PORT_B=1, return-tag typedef {valid, port}.
- One natural sub-module: rr_arbiter2 (2-way round-robin grant plus pointer register). The return shift register and muxing stay in dmem_arbiter.

Test Plan:
- Reset: assert rst mid-stream with reads in flight -> all outputs 0 immediately. After release, no stray rvalid and the first contention grants A.
- Single port: A writes 0xDEADBEEF @3, then reads @3 -> a_gnt on both requests. a_rvalid 2 cycles after the read grant with a_rdata=0xDEADBEEF. b_* stays idle.
- Contention: A and B both read continuously (A @1, B @2 preloaded 0x11/0x22) -> grants alternate A,B,A,B. a_rvalid/b_rvalid alternate with 0x11/0x22, never both high.
- Write/read race: B writes 0x55 @7 in cycle N while A waits; A reads @7 in cycle N+1 -> a_rdata=0x55.
- Withdraw: B raises req, is denied due to A priority, then drops req -> no write occurs at B's address (readback unchanged) and the pointer stays consistent.
- Wrap and latency: RD_LAT=2 build, reads @31 then @0 back-to-back -> returns in order, 3 cycles after each grant.
